// File: rtl/complex_operand_sequencer.sv
// rtl/complex_operand_sequencer.sv - captures complex row-blocks and issues ordered operand pairs to the MAC array
module complex_operand_sequencer #(
   parameter int WORD_LEN   = 16,
   parameter int MATRIX_DIM = 4,
   localparam int VW        = WORD_LEN * MATRIX_DIM
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    mode,
   input  logic [VW-1:0] ar_row,
   input  logic [VW-1:0] ai_row,
   input  logic [VW-1:0] br_row,
   input  logic [VW-1:0] bi_row,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [VW-1:0] mx,
   output logic [VW-1:0] my,
   output logic [1:0]    term,
   output logic          dest_imag,
   output logic          sub,
   output logic          last
);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t        state;
   logic [VW-1:0] ar_q, ai_q, br_q, bi_q;
   logic          conj_q;

   logic [1:0]    nxt_term;
   logic [VW-1:0] nxt_mx, nxt_my;
   logic          nxt_dest_imag, nxt_sub, nxt_last;

   assign in_ready = (state == IDLE) && !flush;

   // Term 0 is loaded straight from the input rows at capture, so this only
   // needs to cover the advance from the captured copies.
   always_comb begin
      nxt_term      = term + 2'd1;
      nxt_mx        = ar_q;
      nxt_my        = br_q;
      nxt_dest_imag = 1'b0;
      nxt_sub       = 1'b0;
      nxt_last      = (nxt_term == 2'd3);
      case (nxt_term)
         2'd1: begin
            nxt_mx  = ai_q;
            nxt_my  = bi_q;
            nxt_sub = !conj_q;
         end
         2'd2: begin
            nxt_mx        = ar_q;
            nxt_my        = bi_q;
            nxt_dest_imag = 1'b1;
            nxt_sub       = conj_q;
         end
         2'd3: begin
            nxt_mx        = ai_q;
            nxt_my        = br_q;
            nxt_dest_imag = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         term      <= 2'd0;
         dest_imag <= 1'b0;
         sub       <= 1'b0;
         last      <= 1'b0;
         mx        <= '0;
         my        <= '0;
         ar_q      <= '0;
         ai_q      <= '0;
         br_q      <= '0;
         bi_q      <= '0;
         conj_q    <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         last      <= 1'b0;
         term      <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  ar_q      <= ar_row;
                  ai_q      <= ai_row;
                  br_q      <= br_row;
                  bi_q      <= bi_row;
                  conj_q    <= (mode == 2'b10);
                  mx        <= ar_row;
                  my        <= br_row;
                  term      <= 2'd0;
                  dest_imag <= 1'b0;
                  sub       <= 1'b0;
                  // Real-only blocks are a single beat.
                  last      <= (mode == 2'b00);
                  out_valid <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (out_valid && out_ready) begin
                  if (last) begin
                     out_valid <= 1'b0;
                     last      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     term      <= nxt_term;
                     mx        <= nxt_mx;
                     my        <= nxt_my;
                     dest_imag <= nxt_dest_imag;
                     sub       <= nxt_sub;
                     last      <= nxt_last;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_complex_operand_sequencer.sv
// tb/tb_complex_operand_sequencer.sv - directed self-checking bench for complex_operand_sequencer
module tb_complex_operand_sequencer;

   localparam int VW = 64;
   localparam logic [VW-1:0] AR1 = {4{16'h1111}};
   localparam logic [VW-1:0] AI1 = {4{16'h2222}};
   localparam logic [VW-1:0] BR1 = {4{16'h3333}};
   localparam logic [VW-1:0] BI1 = {4{16'h4444}};
   localparam logic [VW-1:0] AR2 = 64'hA000_A001_A002_A003;
   localparam logic [VW-1:0] AI2 = 64'hB000_B001_B002_B003;
   localparam logic [VW-1:0] BR2 = 64'hC000_C001_C002_C003;
   localparam logic [VW-1:0] BI2 = 64'hD000_D001_D002_D003;
   localparam logic [VW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

   typedef logic [VW+VW+2+4-1:0] beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    mode = 2'b00;
   logic [VW-1:0] ar_row = '0, ai_row = '0, br_row = '0, bi_row = '0;
   logic          flush = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [VW-1:0] mx, my;
   logic [1:0]    term;
   logic          dest_imag, sub, last;

   int pass_cnt = 0;
   int total_cnt = 0;

   complex_operand_sequencer #(.WORD_LEN(16), .MATRIX_DIM(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .ar_row(ar_row), .ai_row(ai_row), .br_row(br_row),
      .bi_row(bi_row), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .mx(mx), .my(my), .term(term),
      .dest_imag(dest_imag), .sub(sub), .last(last)
   );

   always #5 clk = ~clk;

   // Called at a negedge; returns at the negedge where beat 0 is visible.
   task automatic start_block(input logic [1:0] m, input logic [VW-1:0] a_r,
                              input logic [VW-1:0] a_i, input logic [VW-1:0] b_r,
                              input logic [VW-1:0] b_i);
      mode = m; ar_row = a_r; ai_row = a_i; br_row = b_r; bi_row = b_i;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [VW+VW+5-1:0] got;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      got = {out_valid, last, term, mx, my, in_ready};
      total_cnt++;
      if (got !== {1'b0, 1'b0, 2'd0, {VW{1'b0}}, {VW{1'b0}}, 1'b1})
         $display("FAIL reset_hold: got %h expected %h", got, {1'b0, 1'b0, 2'd0, {VW{1'b0}}, {VW{1'b0}}, 1'b1});
      else pass_cnt++;
      rst_n = 1'b1;
      @(negedge clk);
      got = {out_valid, last, term, mx, my, in_ready};
      total_cnt++;
      if (got !== {1'b0, 1'b0, 2'd0, {VW{1'b0}}, {VW{1'b0}}, 1'b1})
         $display("FAIL reset_release: got %h expected %h", got, {1'b0, 1'b0, 2'd0, {VW{1'b0}}, {VW{1'b0}}, 1'b1});
      else pass_cnt++;
   endtask

   task automatic test_full_complex();
      logic [VW-1:0] e_mx [4];
      logic [VW-1:0] e_my [4];
      logic [3:0] e_di = 4'b1100, e_sub = 4'b0010, e_last = 4'b1000;
      beat_t got, exp;
      e_mx = '{AR1, AI1, AR1, AI1};
      e_my = '{BR1, BI1, BI1, BR1};
      out_ready = 1'b1;
      start_block(2'b01, AR1, AI1, BR1, BI1);
      for (int k = 0; k < 4; k++) begin
         got = {mx, my, term, dest_imag, sub, last, out_valid};
         exp = {e_mx[k], e_my[k], 2'(k), e_di[k], e_sub[k], e_last[k], 1'b1};
         total_cnt++;
         if (got !== exp) $display("FAIL full_beat%0d: got %h expected %h", k, got, exp);
         else pass_cnt++;
         total_cnt++;
         if (in_ready !== 1'b0) $display("FAIL full_busy%0d: in_ready got %b expected 0", k, in_ready);
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if ({out_valid, last, in_ready} !== 3'b001)
         $display("FAIL full_done: {out_valid,last,in_ready} got %b expected 001", {out_valid, last, in_ready});
      else pass_cnt++;
   endtask

   task automatic test_conj_backpressure();
      beat_t got, exp;
      out_ready = 1'b1;
      start_block(2'b10, AR2, AI2, BR2, BI2);
      got = {mx, my, term, dest_imag, sub, last, out_valid};
      exp = {AR2, BR2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1};
      total_cnt++;
      if (got !== exp) $display("FAIL conj_beat0: got %h expected %h", got, exp);
      else pass_cnt++;
      @(negedge clk);
      got = {mx, my, term, dest_imag, sub, last, out_valid};
      exp = {AI2, BI2, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1};
      total_cnt++;
      if (got !== exp) $display("FAIL conj_beat1: got %h expected %h", got, exp);
      else pass_cnt++;
      @(negedge clk);
      out_ready = 1'b0;
      exp = {AR2, BI2, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         got = {mx, my, term, dest_imag, sub, last, out_valid};
         total_cnt++;
         if (got !== exp) $display("FAIL conj_stall%0d: got %h expected %h", k, got, exp);
         else pass_cnt++;
         if (k < 3) @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      got = {mx, my, term, dest_imag, sub, last, out_valid};
      exp = {AI2, BR2, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1};
      total_cnt++;
      if (got !== exp) $display("FAIL conj_beat3: got %h expected %h", got, exp);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL conj_done: {out_valid,in_ready} got %b expected 01", {out_valid, in_ready});
      else pass_cnt++;
   endtask

   task automatic test_real_only();
      beat_t got, exp;
      out_ready = 1'b1;
      start_block(2'b00, AR2, AI2, BR2, BI2);
      got = {mx, my, term, dest_imag, sub, last, out_valid};
      exp = {AR2, BR2, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1};
      total_cnt++;
      if (got !== exp) $display("FAIL real_beat: got %h expected %h", got, exp);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({out_valid, last, in_ready} !== 3'b001)
         $display("FAIL real_done: {out_valid,last,in_ready} got %b expected 001", {out_valid, last, in_ready});
      else pass_cnt++;
   endtask

   task automatic test_mode11();
      logic [VW-1:0] e_mx [4];
      logic [VW-1:0] e_my [4];
      logic [3:0] e_di = 4'b1100, e_sub = 4'b0010, e_last = 4'b1000;
      beat_t got, exp;
      e_mx = '{AR2, AI2, AR2, AI2};
      e_my = '{BR2, BI2, BI2, BR2};
      out_ready = 1'b1;
      start_block(2'b11, AR2, AI2, BR2, BI2);
      for (int k = 0; k < 4; k++) begin
         got = {mx, my, term, dest_imag, sub, last, out_valid};
         exp = {e_mx[k], e_my[k], 2'(k), e_di[k], e_sub[k], e_last[k], 1'b1};
         total_cnt++;
         if (got !== exp) $display("FAIL mode11_beat%0d: got %h expected %h", k, got, exp);
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL mode11_done: {out_valid,in_ready} got %b expected 01", {out_valid, in_ready});
      else pass_cnt++;
   endtask

   task automatic test_flush();
      out_ready = 1'b1;
      start_block(2'b01, AR1, AI1, BR1, BI1);
      @(negedge clk);
      total_cnt++;
      if ({out_valid, term} !== 3'b101)
         $display("FAIL flush_pre: {out_valid,term} got %b expected 101", {out_valid, term});
      else pass_cnt++;
      flush = 1'b1;
      in_valid = 1'b1;
      mode = 2'b00; ar_row = AR2; br_row = BR2;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", in_ready);
      else pass_cnt++;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, last, term, in_ready} !== 5'b00001)
         $display("FAIL flush_after: {out_valid,last,term,in_ready} got %b expected 00001", {out_valid, last, term, in_ready});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL flush_no_capture: {out_valid,in_ready} got %b expected 01", {out_valid, in_ready});
      else pass_cnt++;
   endtask

   task automatic test_ignore_busy();
      logic [VW-1:0] e_mx [4];
      logic [VW-1:0] e_my [4];
      logic [3:0] e_di = 4'b1100, e_sub = 4'b0010, e_last = 4'b1000;
      beat_t got, exp;
      e_mx = '{AR1, AI1, AR1, AI1};
      e_my = '{BR1, BI1, BI1, BR1};
      out_ready = 1'b1;
      start_block(2'b01, AR1, AI1, BR1, BI1);
      mode = 2'b00; ar_row = JUNK; ai_row = ~JUNK; br_row = AR2; bi_row = BI2;
      for (int k = 0; k < 4; k++) begin
         got = {mx, my, term, dest_imag, sub, last, out_valid};
         exp = {e_mx[k], e_my[k], 2'(k), e_di[k], e_sub[k], e_last[k], 1'b1};
         total_cnt++;
         if (got !== exp) $display("FAIL busy_beat%0d: got %h expected %h", k, got, exp);
         else pass_cnt++;
         in_valid = (k < 3) && (k % 2 == 0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      total_cnt++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL busy_done: {out_valid,in_ready} got %b expected 01", {out_valid, in_ready});
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b1;
      start_block(2'b01, AR2, AI2, BR2, BI2);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, last, term} !== 4'b0000)
         $display("FAIL areset_now: {out_valid,last,term} got %b expected 0000", {out_valid, last, term});
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({out_valid, in_ready, term, mx, my} !== {1'b0, 1'b1, 2'd0, {VW{1'b0}}, {VW{1'b0}}})
         $display("FAIL areset_release: got %h expected %h", {out_valid, in_ready, term, mx, my},
                  {1'b0, 1'b1, 2'd0, {VW{1'b0}}, {VW{1'b0}}});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (out_valid !== 1'b0) $display("FAIL areset_no_beat: out_valid got %b expected 0", out_valid);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_full_complex();
      test_conj_backpressure();
      test_real_only();
      test_mode11();
      test_flush();
      test_ignore_busy();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/complex_operand_sequencer.md
Name: complex_operand_sequencer

Overview:
- Parametrised, sequential successor to the combinational real/imag block select in the complex matrix-multiply datapath.
- Captures one row-block of A (real and imaginary) and one of B (real and imaginary) through a valid/ready handshake.
- Emits the operand pairs for each partial product in order over a second valid/ready handshake to the MAC array.
- Tags each beat with its destination accumulator (real or imaginary) and add/subtract sign.
- Supports real-only, full-complex and conjugate-B modes.

Parameters:
- WORD_LEN, 16, bits per matrix element.
- MATRIX_DIM, 4, elements per row vector. Vector width VW = WORD_LEN*MATRIX_DIM.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input row-block valid.
- in_ready  out  1  sequencer can accept a row-block.
- mode  in  2  00 real-only, 01 full complex, 10 conjugate B, 11 treated as 01. Sampled at capture.
- ar_row  in  VW  A real row.
- ai_row  in  VW  A imaginary row.
- br_row  in  VW  B real row.
- bi_row  in  VW  B imaginary row.
- flush  in  1  synchronous abort.
- out_valid  out  1  operand pair valid.
- out_ready  in  1  MAC array accepts pair.
- mx  out  VW  first operand vector.
- my  out  VW  second operand vector.
- term  out  2  partial-product index 0..3.
- dest_imag  out  1  0 = real accumulator, 1 = imaginary accumulator.
- sub  out  1  1 = subtract product from accumulator.
- last  out  1  final beat of this row-block.

Behaviour:
- States: IDLE and ISSUE. in_ready = (state==IDLE) && !flush.
- Reset (rst_n low, async):
  - state = IDLE.
  - out_valid, term, dest_imag, sub and last = 0.
  - mx, my and the captured row registers = 0.
- IDLE:
  - On in_valid && in_ready at edge k, capture all four rows and mode.
  - Load the term-0 beat into the output registers, set out_valid = 1, enter ISSUE.
  - First beat is visible in the cycle after edge k (1-cycle latency).
- Beat table (term: mx, my, dest_imag, sub):
  - mode 01: 0: ar, br, 0, 0 | 1: ai, bi, 0, 1 | 2: ar, bi, 1, 0 | 3: ai, br, 1, 0.
  - mode 10: 0: ar, br, 0, 0 | 1: ai, bi, 0, 0 | 2: ar, bi, 1, 1 | 3: ai, br, 1, 0.
  - mode 00: single beat, term 0 only: ar, br, 0, 0.
- ISSUE:
  - Outputs are registered and held stable while out_valid && !out_ready.
  - On out_valid && out_ready with !last: advance term by 1 and load that beat at the same edge. No bubble between beats.
  - On out_valid && out_ready with last: out_valid = 0, last = 0, return to IDLE. in_ready is high the following cycle.
  - last = 1 exactly on term 3 (modes 01, 10, 11) or term 0 (mode 00).
- Throughput: with out_ready held high, full complex gives 4 beats per 5 cycles.
- in_valid during ISSUE is ignored (in_ready = 0). Changes on the input rows or mode during ISSUE have no effect.
- flush:
  - In any state, at the next edge: out_valid = 0, last = 0, term = 0, state = IDLE.
  - flush takes priority over a simultaneous out_ready or in_valid. No capture occurs in a flush cycle.
- An async reset mid-ISSUE aborts the sequence immediately. No partial beat is reported after reset release.
- No arithmetic is performed; vectors pass through bit-exact.

Test Plan:
- Reset & idle:
  - Assert rst_n = 0 mid-ISSUE.
  - Required: out_valid = 0 immediately.
  - After release: in_ready = 1, term = 0, mx = my = 0.
- Full complex, out_ready = 1:
  - Stimulus: mode = 01, ar = 64'h1111…, ai = 64'h2222…, br = 64'h3333…, bi = 64'h4444….
  - Required: 4 consecutive beats (mx, my) = (1, 3), (2, 4), (1, 4), (2, 3).
  - Flags (dest_imag, sub) = 00, 01, 10, 10; last only on beat 4; in_ready high one cycle later.
- Conjugate with backpressure:
  - Stimulus: mode = 10, out_ready low for 3 cycles on term 2.
  - Required: mx, my and flags held stable; term 2 shows sub = 1; term 1 shows sub = 0.
- Real-only:
  - Stimulus: mode = 00.
  - Required: single beat (ar, br) with last = 1; return to IDLE after accept. Mode 11 sequences exactly like 01.
- Flush:
  - Stimulus: assert flush on term 1 together with out_ready and in_valid.
  - Required: out_valid = 0 next cycle, no capture; in_ready = 1 once flush deasserts.
- Input ignored while busy:
  - Stimulus: toggle in_valid and change all rows during ISSUE.
  - Required: outputs still reflect the originally captured rows.
